// File: rtl/prewitt_pkg.sv
// Shared constants for the streaming Prewitt edge detector: combination modes,
// FSM state encoding and gradient sizing.
package prewitt_pkg;

  localparam logic [1:0] MODE_LEGACY  = 2'd0;
  localparam logic [1:0] MODE_ABS_SUM = 2'd1;
  localparam logic [1:0] MODE_MAX     = 2'd2;
  localparam logic [1:0] MODE_THRESH  = 2'd3;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Three guard bits hold a signed difference of two 3-pixel sums without overflow
  localparam int GRAD_GUARD = 3;

  function automatic int grad_width(input int pix_w);
    return pix_w + GRAD_GUARD;
  endfunction

endpackage

// File: rtl/prewitt_line_buffer.sv
// Enable-gated delay line of DEPTH samples: the output seen while enable is high
// is the sample written DEPTH enables earlier.
module prewitt_line_buffer
  import prewitt_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_q
);

  // DEPTH-1 RAM words plus the registered read port make up the full delay
  localparam int D  = DEPTH - 1;
  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam logic [AW-1:0] ADDR_LAST = AW'(D - 1);

  logic [W-1:0]  r_mem [0:D-1];
  logic [W-1:0]  r_q;
  logic [AW-1:0] r_addr;

  // Read-before-write RAM access, no reset so it maps onto block memory
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_q           <= r_mem[r_addr];
      r_mem[r_addr] <= i_data;
    end
  end

  // Circular address pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= {AW{1'b0}};
    end else if (i_en) begin
      r_addr <= (r_addr == ADDR_LAST) ? {AW{1'b0}} : r_addr + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/prewitt_stream.sv
// Streaming Prewitt edge detector: two line buffers and a 3x3 window produce one
// registered edge pixel per input pixel, in raster order, with selectable combination.
module prewitt_stream
  import prewitt_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int COLS  = 256,
  parameter int ROWS  = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic [1:0]       mode,
  input  logic [PIX_W+2:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             frame_done
);

  localparam int GW  = grad_width(PIX_W);
  localparam int GW1 = GW + 1;
  localparam int CW  = $clog2(COLS);
  localparam int RW  = $clog2(ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [GW:0]   PIX_MAX  = GW1'((1 << PIX_W) - 1);

  state_t           r_state;
  logic             r_started;
  logic [1:0]       r_mode;
  logic [GW-1:0]    r_thresh;
  logic [CW-1:0]    r_icol, r_ocol;
  logic [RW-1:0]    r_irow, r_orow;
  logic [PIX_W-1:0] r_t0, r_t1, r_m0, r_m1, r_b0, r_b1;
  logic             r_out_valid, r_out_last;
  logic [PIX_W-1:0] r_out_pixel;

  logic                w_in_ready, w_in_fire, w_out_load, w_frame_end;
  logic                w_in_last, w_out_last, w_border;
  logic [PIX_W-1:0]    w_m2, w_t2, w_result;
  logic signed [GW-1:0] w_gx, w_gy;
  logic [GW-1:0]       w_ax, w_ay;
  logic [GW:0]         w_abs_sum, w_legacy, w_mag;

  function automatic logic signed [GW-1:0] widen(input logic [PIX_W-1:0] p);
    return $signed({{GRAD_GUARD{1'b0}}, p});
  endfunction

  prewitt_line_buffer #(.W(PIX_W), .DEPTH(COLS)) u_lb_mid (
    .clk(clk), .rst_n(rst_n), .i_en(w_in_fire), .i_data(in_pixel), .o_q(w_m2)
  );

  prewitt_line_buffer #(.W(PIX_W), .DEPTH(COLS)) u_lb_top (
    .clk(clk), .rst_n(rst_n), .i_en(w_in_fire), .i_data(w_m2), .o_q(w_t2)
  );

  assign w_in_fire  = in_valid && w_in_ready;
  assign w_in_last  = (r_irow == ROW_LAST) && (r_icol == COL_LAST);
  assign w_out_last = (r_orow == ROW_LAST) && (r_ocol == COL_LAST);
  assign w_border   = (r_orow == {RW{1'b0}}) || (r_orow == ROW_LAST) ||
                      (r_ocol == {CW{1'b0}}) || (r_ocol == COL_LAST);

  // Input acceptance per state; held low until the first edge after reset
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      ST_FILL:  w_in_ready = r_started;
      ST_RUN:   w_in_ready = r_started && (!r_out_valid || out_ready);
      ST_FLUSH: w_in_ready = 1'b0;
      default:  w_in_ready = 1'b0;
    endcase
  end

  // Output-register load and end-of-frame decisions
  always_comb begin
    w_out_load  = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      ST_RUN: w_out_load = w_in_fire;
      ST_FLUSH: begin
        if (!r_out_valid || out_ready) begin
          w_frame_end = r_out_valid && r_out_last;
          w_out_load  = !(r_out_valid && r_out_last);
        end else begin
          w_frame_end = 1'b0;
          w_out_load  = 1'b0;
        end
      end
      default: w_out_load = 1'b0;
    endcase
  end

  // Window: right column is the live pixel plus both line-buffer taps
  assign w_gx = (widen(r_t0) + widen(r_t1) + widen(w_t2))
              - (widen(r_b0) + widen(r_b1) + widen(in_pixel));
  assign w_gy = (widen(r_t0) + widen(r_m0) + widen(r_b0))
              - (widen(w_t2) + widen(w_m2) + widen(in_pixel));
  assign w_ax = w_gx[GW-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
  assign w_ay = w_gy[GW-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
  assign w_abs_sum = {1'b0, w_ax} + {1'b0, w_ay};
  assign w_legacy  = (w_gx[GW-1] ? {GW1{1'b0}} : {1'b0, $unsigned(w_gx)})
                   + (w_gy[GW-1] ? {GW1{1'b0}} : {1'b0, $unsigned(w_gy)});

  // Mode combination with saturation
  always_comb begin
    w_mag    = w_abs_sum;
    w_result = {PIX_W{1'b0}};
    case (r_mode)
      MODE_LEGACY:  w_mag = w_legacy;
      MODE_ABS_SUM: w_mag = w_abs_sum;
      MODE_MAX:     w_mag = (w_ax > w_ay) ? {1'b0, w_ax} : {1'b0, w_ay};
      default:      w_mag = w_abs_sum;
    endcase
    if (r_mode == MODE_THRESH) begin
      w_result = (w_abs_sum >= {1'b0, r_thresh}) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
    end else if (w_mag > PIX_MAX) begin
      w_result = {PIX_W{1'b1}};
    end else begin
      w_result = w_mag[PIX_W-1:0];
    end
  end

  // FSM, per-frame configuration latch and the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_FILL;
      r_started   <= 1'b0;
      r_mode      <= MODE_LEGACY;
      r_thresh    <= {GW{1'b0}};
      r_out_valid <= 1'b0;
      r_out_pixel <= {PIX_W{1'b0}};
      r_out_last  <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (w_in_fire && (r_state == ST_FILL) &&
          (r_irow == {RW{1'b0}}) && (r_icol == {CW{1'b0}})) begin
        r_mode   <= mode;
        r_thresh <= thresh;
      end
      case (r_state)
        ST_FILL: begin
          if (w_in_fire && (r_irow == RW'(1)) && (r_icol == {CW{1'b0}})) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_in_fire && w_in_last) r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (w_frame_end) r_state <= ST_FILL;
        end
        default: r_state <= ST_FILL;
      endcase
      if (w_out_load) begin
        r_out_valid <= 1'b1;
        r_out_pixel <= w_border ? {PIX_W{1'b0}} : w_result;
        r_out_last  <= w_out_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  // Raster counters; the output pair selects border pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icol <= {CW{1'b0}};
      r_irow <= {RW{1'b0}};
      r_ocol <= {CW{1'b0}};
      r_orow <= {RW{1'b0}};
    end else begin
      if (w_in_fire) begin
        if (r_icol == COL_LAST) begin
          r_icol <= {CW{1'b0}};
          r_irow <= (r_irow == ROW_LAST) ? {RW{1'b0}} : r_irow + 1'b1;
        end else begin
          r_icol <= r_icol + 1'b1;
        end
      end
      if (w_out_load) begin
        if (r_ocol == COL_LAST) begin
          r_ocol <= {CW{1'b0}};
          r_orow <= (r_orow == ROW_LAST) ? {RW{1'b0}} : r_orow + 1'b1;
        end else begin
          r_ocol <= r_ocol + 1'b1;
        end
      end
    end
  end

  // Window shift on every accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t0 <= {PIX_W{1'b0}};
      r_t1 <= {PIX_W{1'b0}};
      r_m0 <= {PIX_W{1'b0}};
      r_m1 <= {PIX_W{1'b0}};
      r_b0 <= {PIX_W{1'b0}};
      r_b1 <= {PIX_W{1'b0}};
    end else if (w_in_fire) begin
      r_t0 <= r_t1;
      r_t1 <= w_t2;
      r_m0 <= r_m1;
      r_m1 <= w_m2;
      r_b0 <= r_b1;
      r_b1 <= in_pixel;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_pixel  = r_out_pixel;
  assign frame_done = r_out_valid && out_ready && r_out_last;

endmodule

// File: tb/tb_prewitt_stream.sv
// Directed and randomized frames through prewitt_stream, checked against a
// frame-level Prewitt model computed from the image array.
module tb_prewitt_stream;
  import prewitt_pkg::*;

  localparam int PIX_W = 8;
  localparam int COLS  = 16;
  localparam int ROWS  = 12;
  localparam int N     = COLS * ROWS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel = 8'd0;
  logic [1:0]       mode = 2'd0;
  logic [PIX_W+2:0] thresh = 11'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [PIX_W-1:0] out_pixel;
  logic             frame_done;

  int checks = 0;
  int failures = 0;
  int img [ROWS][COLS];
  int exp_q [$];

  always #5 clk = ~clk;

  prewitt_stream #(.PIX_W(PIX_W), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .mode(mode), .thresh(thresh), .out_valid(out_valid),
    .out_ready(out_ready), .out_pixel(out_pixel), .frame_done(frame_done)
  );

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Edge value of pixel (r,c) straight from the gradient definitions
  function automatic int model(input int r, input int c, input int md, input int th);
    int gx, gy, ax, ay, v;
    if (r == 0 || r == ROWS-1 || c == 0 || c == COLS-1) return 0;
    gx = (img[r-1][c-1] + img[r-1][c] + img[r-1][c+1])
       - (img[r+1][c-1] + img[r+1][c] + img[r+1][c+1]);
    gy = (img[r-1][c-1] + img[r][c-1] + img[r+1][c-1])
       - (img[r-1][c+1] + img[r][c+1] + img[r+1][c+1]);
    ax = iabs(gx);
    ay = iabs(gy);
    case (md)
      0: v = ((gx > 0) ? gx : 0) + ((gy > 0) ? gy : 0);
      1: v = ax + ay;
      2: v = (ax > ay) ? ax : ay;
      default: return (ax + ay >= th) ? 255 : 0;
    endcase
    return (v > 255) ? 255 : v;
  endfunction

  // Streams n_in pixels of img; a full frame also waits for every output
  task automatic run_frame(input int md, input int th, input int n_in, input bit stall,
                           input bit gaps, input bit scramble, input bit no_bubble);
    int acc = 0;
    int outs = 0;
    int cyc = 0;
    bit done = 1'b0;
    bit seen_valid = 1'b0;
    bit held = 1'b0;
    int held_pix = 0;
    bit fire_i, fire_o;
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back(model(k / COLS, k % COLS, md, th));
    mode   = 2'(md);
    thresh = 11'(th);
    while (!done && cyc < 40 * N) begin
      @(negedge clk);
      cyc++;
      if (scramble && acc > 0) begin
        mode   = 2'($urandom_range(0, 3));
        thresh = 11'($urandom_range(0, 2047));
      end
      in_valid  = (acc < n_in) && (!gaps || ($urandom_range(0, 3) != 0));
      in_pixel  = (acc < N) ? 8'(img[acc / COLS][acc % COLS]) : 8'd0;
      out_ready = !stall || ($urandom_range(0, 1) == 1);
      #1;
      if (held) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_pixel", int'(out_pixel), held_pix);
      end
      if (out_valid && !seen_valid) begin
        seen_valid = 1'b1;
        check("first_output_latency", acc, COLS + 2);
      end
      if (no_bubble && acc < n_in) check("no_bubble_in_ready", int'(in_ready), 1);
      if (acc == N) check("flush_in_ready", int'(in_ready), 0);
      fire_i = in_valid && in_ready;
      fire_o = out_valid && out_ready;
      if (fire_o) begin
        if (exp_q.size() == 0) check("output_overrun", outs + 1, N);
        else check($sformatf("pixel[%0d]", outs), int'(out_pixel), exp_q.pop_front());
        outs++;
      end
      check("frame_done", int'(frame_done), int'(fire_o && outs == N));
      held     = out_valid && !out_ready;
      held_pix = int'(out_pixel);
      if (fire_i) acc++;
      done = (n_in < N) ? (acc == n_in) : (fire_o && outs == N);
    end
    check("frame_completed", int'(done), 1);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_pixel", int'(out_pixel), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_in_ready", int'(in_ready), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      out_ready = ($urandom_range(0, 1) == 1);
      #1;
      check_reset_outputs();
      @(negedge clk);
    end
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", int'(in_ready), 0);
    @(negedge clk);
    check("in_ready_after_edge", int'(in_ready), 1);
  endtask

  initial begin
    do_reset();

    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) img[r][c] = 100;
    run_frame(int'(MODE_ABS_SUM), 0, N, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) img[r][c] = (c < COLS/2) ? 0 : 50;
    run_frame(int'(MODE_ABS_SUM), 0, N, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(int'(MODE_LEGACY), 0, N, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(int'(MODE_THRESH), 100, N, 1'b0, 1'b1, 1'b1, 1'b0);

    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) img[r][c] = (r < ROWS/2) ? 200 : 0;
    run_frame(int'(MODE_ABS_SUM), 0, N, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(int'(MODE_MAX), 0, N, 1'b1, 1'b1, 1'b1, 1'b0);

    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) img[r][c] = int'($urandom_range(0, 255));
    run_frame(int'(MODE_ABS_SUM), 0, N, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(int'(MODE_ABS_SUM), 0, N, 1'b1, 1'b1, 1'b1, 1'b0);
    run_frame(int'(MODE_LEGACY), 0, N, 1'b1, 1'b1, 1'b1, 1'b0);
    run_frame(int'(MODE_MAX), 0, N, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame(int'(MODE_THRESH), int'($urandom_range(100, 900)), N, 1'b1, 1'b1, 1'b1, 1'b0);

    run_frame(int'(MODE_MAX), 0, 100, 1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    run_frame(int'(MODE_ABS_SUM), 0, N, 1'b1, 1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prewitt_stream.md
# prewitt_stream

Streaming, parametrised Prewitt edge detector that replaces the frame-at-once behavioural model. It accepts a raster-order pixel stream over a valid/ready handshake and holds two line buffers plus a 3×3 window. It emits one edge pixel per input pixel in the same raster order, with a selectable gradient-combination mode. It sits between the image source and the output writer / downstream stage of the edge pipeline.

## Interface
- `PIX_W`, 8: pixel width in bits; output saturates at 2^PIX_W−1.
- `COLS`, 256: frame width; must be ≥ 3.
- `ROWS`, 256: frame height; must be ≥ 3.
- `clk`  in  1  rising-edge clock; the only clock in the block.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  input pixel valid.
- `in_ready`  out  1  block accepts `in_pixel` when `in_valid` and `in_ready` are both high.
- `in_pixel`  in  PIX_W  unsigned input pixel, raster order.
- `mode`  in  2  combination mode, sampled with the first pixel of each frame.
- `thresh`  in  PIX_W+3  binary threshold for mode 3, sampled with `mode`.
- `out_valid`  out  1  output pixel valid.
- `out_ready`  in  1  downstream accepts the output.
- `out_pixel`  out  PIX_W  edge magnitude.
- `frame_done`  out  1  one-cycle pulse on the handshake of the last output pixel of a frame.

## Operation
- Gradients are computed over the 3×3 window centred at (r,c).
  - gx = (top-row sum) − (bottom-row sum).
  - gy = (left-column sum) − (right-column sum).
  - Both are signed, PIX_W+3 bits, computed without overflow.
- Mode 0 (LEGACY): negative gx and gy clamp to 0; result is gx+gy.
- Mode 1 (ABS_SUM): result is |gx|+|gy|.
- Mode 2 (MAX): result is max(|gx|,|gy|).
- Mode 3 (THRESH): result is all-ones if |gx|+|gy| ≥ `thresh`, else 0.
- Modes 0–2 saturate the result to 2^PIX_W−1.
- Border pixels (r=0, r=ROWS−1, c=0, c=COLS−1) output 0 in every mode.
- Exactly ROWS×COLS outputs are produced per frame, in raster order.
- State machine:
  - FILL: accept the first COLS+1 pixels; no outputs.
  - RUN: each accepted input k+COLS+1 produces output k.
  - FLUSH: after the last input is accepted, hold `in_ready`=0 and emit the remaining COLS+1 outputs. All of these are border pixels, so all are 0.
  - After FLUSH, return to FILL for the next frame.
- `mode` and `thresh` are latched on the first accepted pixel of a frame. Changes mid-frame have no effect on that frame.
- Input and output row/column counters wrap at COLS−1 and ROWS−1. The output counters drive the border decision.

## Timing
- Reset values: `out_valid`=0, `out_pixel`=0, `frame_done`=0, `in_ready`=0 while `rst_n` is low. State is FILL, all counters are 0, and the latched mode is 0.
- `in_ready` rises on the first clock edge after `rst_n` deasserts.
- Output k is registered and presented on the cycle after input k+COLS+1 is accepted.
  - First-pixel latency is COLS+2 accepted inputs plus 1 cycle.
- In FILL: `in_ready`=1.
- In RUN: `in_ready` = !`out_valid` || `out_ready`. Full throughput is one pixel per cycle with no bubbles.
- `out_pixel` and `out_valid` stay stable while `out_valid`=1 and `out_ready`=0.
- FLUSH emits one output per cycle whenever `out_ready`=1.
- The first FILL accept of the next frame may occur in the cycle after the final FLUSH handshake.
- Reset asserted mid-frame discards all partial state. Line-buffer contents need not be cleared, because FILL overwrites them before any use.

## Structure
- `prewitt_pkg` holds:
  - mode constants MODE_LEGACY=0, MODE_ABS_SUM=1, MODE_MAX=2, MODE_THRESH=3;
  - state encodings FILL/RUN/FLUSH;
  - the gradient width constant (PIX_W+3).
- Sub-module `prewitt_line_buffer` is a COLS-deep, PIX_W-wide, enable-gated delay line. It is instantiated twice, in a chain. It must map to RAM for large COLS.
- The top level holds:
  - the window registers;
  - the row/column counters and FSM;
  - the combinational gradient and mode logic, feeding the single output register.

## Test plan
- Constant frame of 100, mode 1, `out_ready`=1 → 65536 zero outputs, one `frame_done`, zero gap between inputs.
- Vertical step (c<128 → 0, c≥128 → 50), interior rows:
  - mode 1 → 150 at c=127 and c=128, 0 elsewhere;
  - mode 0 → all 0 (gy=−150 clamps to 0).
- Horizontal step (r<128 → 200, else 0), mode 1 → gx=600 saturates to 255 at r=127 and r=128; mode 2 gives the same result.
- Vertical step from scenario 2, mode 3, `thresh`=100 → 255 at c=127 and c=128, 0 elsewhere. Changing `mode` mid-frame leaves the output unchanged.
- Random image with `out_ready` at 50% random and `in_valid` gaps → output sequence bit-identical to an unstalled run; `out_pixel` holds while stalled.
- `rst_n` pulsed low after 1000 inputs, then a full random frame → outputs identical to a clean-reset run; all outputs 0 during reset.
